// File: rtl/fast_iter_sequencer.sv
// fast_iter_sequencer: initiator side of the go_fast / fast_busy handshake.
// Each iteration arms the slave (go_fast low), runs it until its busy falls,
// strobes the weight latch and then consumes the convergence verdict. The
// loop ends on convergence or when the iteration limit is reached, and the
// result is reported with a one-cycle done pulse.
// Optional feature: define FAST_WATCHDOG_EN to bound the RUN phase to
// WD_CYCLES cycles; without it RUN waits indefinitely and timeout_err is 0.
module fast_iter_sequencer #(
  parameter int unsigned ITER_W     = 7,
  parameter int unsigned MAX_ITER   = 64,
  parameter int unsigned ARM_CYCLES = 2,
  parameter int unsigned WD_CYCLES  = 1023
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              fast_busy,
  input  logic              conv_valid,
  input  logic              conv_flag,
  output logic              go_fast,
  output logic              w_latch,
  output logic              seq_busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout_err
);

  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  // Reject configurations that cannot work at elaboration time.
  if (ARM_CYCLES < 1 || WD_CYCLES < 1) begin : g_cfg_check
    $error("fast_iter_sequencer: ARM_CYCLES and WD_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_LATCH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ARM_W-1:0]  arm_cnt;
  logic              busy_prev;
  logic [ITER_W-1:0] lim;
  logic              arm_last;
  logic              run_done;
  logic              wd_hit;

  assign arm_last = (arm_cnt == ARM_W'(ARM_CYCLES - 1));
  // Only a falling edge observed after RUN entry counts: busy_prev is held
  // at 0 outside RUN, so a busy already low on entry never completes.
  assign run_done = busy_prev && !fast_busy;

`ifdef FAST_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_hit = (state == S_RUN) && !run_done && (wd_cnt == WD_W'(WD_CYCLES - 1));

  // Watchdog: counts RUN cycles, restarts on every RUN entry.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_RUN) ? wd_cnt + WD_W'(1) : '0;
      if (state == S_IDLE && start) begin
        timeout_q <= 1'b0;
      end else if (wd_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_ARM;
      S_ARM:   if (arm_last) state_n = S_RUN;
      S_RUN: begin
        if (run_done) begin
          state_n = S_LATCH;
        end else if (wd_hit) begin
          state_n = S_DONE;
        end
      end
      S_LATCH: state_n = S_CHECK;
      S_CHECK: begin
        if (conv_valid) begin
          state_n = (conv_flag || iter_count == lim) ? S_DONE : S_ARM;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    go_fast  = (state == S_RUN) || (state == S_LATCH) || (state == S_CHECK);
    w_latch  = (state == S_LATCH);
    seq_busy = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Datapath: arm timer, busy edge tracker, limit, iteration count, result.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      arm_cnt    <= '0;
      busy_prev  <= 1'b0;
      lim        <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
    end else begin
      arm_cnt   <= (state == S_ARM) ? arm_cnt + ARM_W'(1) : '0;
      busy_prev <= (state == S_RUN) ? fast_busy : 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lim        <= (max_iter == '0) ? ITER_W'(MAX_ITER) : max_iter;
            iter_count <= '0;
            converged  <= 1'b0;
          end
        end
        S_RUN: begin
          if (wd_hit) begin
            converged <= 1'b0;
          end
        end
        S_LATCH: begin
          iter_count <= iter_count + ITER_W'(1);
        end
        S_CHECK: begin
          if (conv_valid) begin
            if (conv_flag) begin
              converged <= 1'b1;
            end else if (iter_count == lim) begin
              converged <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_iter_sequencer.sv
// Bench for fast_iter_sequencer: reactive slave and convergence-checker
// models drive the inputs; an analytic timeline model predicts every output
// on every cycle from the run parameters.
module tb_fast_iter_sequencer;

  localparam int A    = 2;     // ARM_CYCLES
  localparam int SB   = 10;    // cycles the slave holds busy high
  localparam int CD   = 3;     // cycles from w_latch to the verdict strobe
  localparam int P    = A + SB + 2 + CD;  // cycles per iteration
  localparam int MAXI = 64;
  localparam int WD   = 1023;

  typedef struct packed {
    logic       go;
    logic       wl;
    logic       sb;
    logic       dn;
    logic       cv;
    logic       to;
    logic [6:0] it;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] max_iter = '0;
  logic       fast_busy = 1'b0;
  logic       conv_valid;
  logic       conv_flag;
  logic       go_fast, w_latch, seq_busy, done, converged, timeout_err;
  logic [6:0] iter_count;

  logic chk_valid = 1'b0, chk_flag = 1'b0, inj_valid = 1'b0;
  assign conv_valid = chk_valid | inj_valid;
  assign conv_flag  = chk_flag | inj_valid;

  always #5 clk = ~clk;

  fast_iter_sequencer #(
    .ITER_W(7), .MAX_ITER(MAXI), .ARM_CYCLES(A), .WD_CYCLES(WD)
  ) dut (
    .clk_fast(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .fast_busy(fast_busy), .conv_valid(conv_valid), .conv_flag(conv_flag),
    .go_fast(go_fast), .w_latch(w_latch), .seq_busy(seq_busy), .done(done),
    .converged(converged), .iter_count(iter_count), .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Run descriptor for the timeline model.
  int   m_f = 0, m_lim = 0, m_conv_iter = 0, m_kill = 0;
  logic m_stall = 1'b0;
  logic m_base_cv = 1'b0, m_base_to = 1'b0;
  logic [6:0] m_base_it = '0;

  function automatic int n_iters();
    return (m_conv_iter != 0 && m_conv_iter <= m_lim) ? m_conv_iter : m_lim;
  endfunction

  function automatic int run_end();
`ifdef FAST_WATCHDOG_EN
    if (m_stall) return m_f + A + WD;
`endif
    return m_f + n_iters() * P;
  endfunction

  function automatic obs_t model_at(input int t);
    obs_t o;
    int   off, k, pos, n;
    o = '0;
    if (t >= m_kill) return o;
    if (t < m_f) begin
      o.cv = m_base_cv; o.to = m_base_to; o.it = m_base_it;
      return o;
    end
    off = t - m_f;
    if (m_stall) begin
      if (off < A) o.sb = 1'b1;
`ifdef FAST_WATCHDOG_EN
      else if (off < A + WD) begin o.sb = 1'b1; o.go = 1'b1; end
      else if (off == A + WD) begin o.sb = 1'b1; o.dn = 1'b1; o.to = 1'b1; end
      else o.to = 1'b1;
`else
      else begin o.sb = 1'b1; o.go = 1'b1; end
`endif
      return o;
    end
    n   = n_iters();
    k   = off / P;
    pos = off % P;
    if (k < n) begin
      o.sb = 1'b1;
      o.go = (pos >= A);
      o.wl = (pos == A + SB + 1);
      o.it = 7'(k + ((pos >= A + SB + 2) ? 1 : 0));
    end else begin
      o.it = 7'(n);
      o.cv = (m_conv_iter != 0 && m_conv_iter <= m_lim);
      if (off == n * P) begin o.sb = 1'b1; o.dn = 1'b1; end
    end
    return o;
  endfunction

  // Slave: raises busy on the first go_fast-high cycle, drops it SB cycles later.
  logic slave_stall = 1'b0, go_seen = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (slave_stall) begin
      fast_busy = 1'b0; bcnt = 0; go_seen = 1'b0;
    end else begin
      if (go_fast && !go_seen) begin fast_busy = 1'b1; bcnt = 1; go_seen = 1'b1; end
      else if (fast_busy && bcnt < SB) bcnt++;
      else fast_busy = 1'b0;
      if (!go_fast) go_seen = 1'b0;
    end
  end

  // Convergence checker: verdict CD cycles after each w_latch.
  int lat_n = 0, cwait = 0;
  always @(negedge clk) begin
    if (chk_valid) begin chk_valid = 1'b0; chk_flag = 1'b0; end
    if (!seq_busy) lat_n = 0;
    if (w_latch) begin
      lat_n++; cwait = CD;
    end else if (cwait > 0) begin
      cwait--;
      if (cwait == 0) begin chk_valid = 1'b1; chk_flag = (lat_n == m_conv_iter); end
    end
  end

  // Event monitor: pulse counts, arm-phase length, result at done.
  int   wl_cnt = 0, rise_cnt = 0, done_cnt = 0, bad_low = 0, low_run = 0;
  logic go_prev = 1'b0, d_cv = 1'b0, d_to = 1'b0, d_go = 1'b0;
  logic [6:0] d_it = '0;
  always @(negedge clk) begin
    if (w_latch) wl_cnt++;
    if (done) begin done_cnt++; d_it = iter_count; d_cv = converged; d_to = timeout_err; d_go = go_fast; end
    if (go_fast && !go_prev) begin rise_cnt++; if (low_run != A) bad_low++; end
    if (!seq_busy || go_fast) low_run = 0; else low_run++;
    go_prev = go_fast;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_loop();
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        e = model_at(cyc);
        a = {go_fast, w_latch, seq_busy, done, converged, timeout_err, iter_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_compare cyc=%0d got go=%b wl=%b sb=%b dn=%b cv=%b to=%b it=%0d expected go=%b wl=%b sb=%b dn=%b cv=%b to=%b it=%0d",
                   cyc, a.go, a.wl, a.sb, a.dn, a.cv, a.to, a.it, e.go, e.wl, e.sb, e.dn, e.cv, e.to, e.it);
        end
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run(input int mi, input int ci, input logic stall);
    obs_t b;
    @(negedge clk);
    b = model_at(cyc);
    m_base_cv = b.cv; m_base_to = b.to; m_base_it = b.it;
    m_kill = 32'h7fff_ffff;
    m_f = cyc + 1;
    m_lim = (mi == 0) ? MAXI : mi;
    m_conv_iter = ci;
    m_stall = stall;
    max_iter = 7'(mi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    max_iter = 7'd1;  // must not matter after acceptance
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_kill = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  int s_wl, s_rise, s_done, s_bad;

  task automatic snap();
    s_wl = wl_cnt; s_rise = rise_cnt; s_done = done_cnt; s_bad = bad_low;
  endtask

  initial begin
    fork compare_loop(); join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_go_fast", go_fast, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_converged", converged, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Limit of 3, never converges.
    snap();
    start_run(3, 0, 1'b0);
    wait_until(run_end() + 2);
    chk("r1_w_latch_pulses", wl_cnt - s_wl, 3);
    chk("r1_arm_phases", rise_cnt - s_rise, 3);
    chk("r1_arm_len_bad", bad_low - s_bad, 0);
    chk("r1_done_pulses", done_cnt - s_done, 1);
    chk("r1_iter_count", d_it, 3);
    chk("r1_converged", d_cv, 0);

    // Limit of 5, converges on the second verdict.
    snap();
    start_run(5, 2, 1'b0);
    wait_until(run_end() + 2);
    chk("r2_w_latch_pulses", wl_cnt - s_wl, 2);
    chk("r2_iter_count", d_it, 2);
    chk("r2_converged", d_cv, 1);
    chk("r2_go_fast_at_done", d_go, 0);

    // max_iter=0 selects MAX_ITER; stray start pulses including one in DONE.
    snap();
    start_run(0, 0, 1'b0);
    wait_until(m_f + 10);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(m_f + 500);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(run_end());
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(run_end() + 3);
    chk("r3_w_latch_pulses", wl_cnt - s_wl, 64);
    chk("r3_done_pulses", done_cnt - s_done, 1);
    chk("r3_iter_count", d_it, 64);
    chk("r3_idle_after", seq_busy, 0);

    // Reset in the middle of the second iteration's RUN phase.
    start_run(3, 0, 1'b0);
    wait_until(m_f + P + A + 4);
    chk("pre_rst_iter_count", iter_count, 1);
    pulse_reset();
    chk("mid_rst_go_fast", go_fast, 0);
    chk("mid_rst_seq_busy", seq_busy, 0);
    chk("mid_rst_iter_count", iter_count, 0);
    repeat (15) @(negedge clk);
    snap();
    start_run(1, 1, 1'b0);
    wait_until(run_end() + 2);
    chk("restart_iter_count", d_it, 1);
    chk("restart_converged", d_cv, 1);
    chk("restart_done_pulses", done_cnt - s_done, 1);

    // Busy low on RUN entry, stray verdict during RUN.
    slave_stall = 1'b1;
    snap();
    start_run(3, 0, 1'b1);
    wait_until(m_f + A + 5);
    inj_valid = 1'b1; @(negedge clk); inj_valid = 1'b0;
`ifdef FAST_WATCHDOG_EN
    wait_until(run_end() + 2);
    chk("wd_w_latch_pulses", wl_cnt - s_wl, 0);
    chk("wd_done_pulses", done_cnt - s_done, 1);
    chk("wd_timeout_err", d_to, 1);
    chk("wd_iter_count", d_it, 0);
    chk("wd_converged", d_cv, 0);
`else
    wait_until(m_f + A + 60);
    chk("stall_w_latch_pulses", wl_cnt - s_wl, 0);
    chk("stall_done_pulses", done_cnt - s_done, 0);
    chk("stall_go_fast", go_fast, 1);
    chk("stall_timeout_err", timeout_err, 0);
`endif
    pulse_reset();
    slave_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", seq_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
